// File: rtl/alarm_ctrl_pkg.sv
// rtl/alarm_ctrl_pkg.sv - shared state encoding, time limits and alarm-time range check
package alarm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2,
        ST_BAD     = 2'd3
    } state_t;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] HOUR_MAX = 6'd23;
    localparam int         SEC_PER_MIN = 60;

    // True when h:m names a real time of day.
    function automatic logic alarm_time_ok(input logic [5:0] h, input logic [5:0] m);
        return (h <= HOUR_MAX) && (m <= MIN_MAX);
    endfunction

endpackage

// File: rtl/alarm_match.sv
// rtl/alarm_match.sv - alarm time registers with range-checked load and time comparator
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   load, set_hour, set_min  load request and candidate alarm time
//   tick_sec, alarm_en       new-second pulse and arm level
//   sec, min, hour           current time
//   alarm_hour, alarm_min    stored alarm time
//   match                    alarm time reached at the top of the minute
module alarm_match
    import alarm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [5:0] set_hour,
    input  logic [5:0] set_min,
    input  logic       tick_sec,
    input  logic       alarm_en,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [5:0] hour,
    output logic [5:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic       match
);

    // Out-of-range loads are dropped so the stored alarm is always a valid time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alarm_hour <= 6'd0;
            alarm_min  <= 6'd0;
        end else if (load && alarm_time_ok(set_hour, set_min)) begin
            alarm_hour <= set_hour;
            alarm_min  <= set_min;
        end
    end

    // Compared against the registered alarm time; the FSM registers the
    // result, so ring rises one clock after the matching tick.
    assign match = tick_sec & alarm_en & (hour == alarm_hour) &
                   (min == alarm_min) & (sec == 6'd0);

endmodule

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm clock controller: ring, snooze, timeout and missed-alarm tracking
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   tick_sec                 one-clock pulse when sec/min/hour hold a new second
//   sec, min, hour           current time
//   load, set_hour, set_min  alarm time load
//   alarm_en                 arm level; low forces IDLE
//   snooze, stop             user pulses
//   alarm_hour, alarm_min    stored alarm time
//   ring, beep, missed       ringing, tone enable, sticky unacknowledged timeout
//   state                    FSM state code
module alarm_ctrl
    import alarm_ctrl_pkg::*;
#(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_sec,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [5:0] hour,
    input  logic       load,
    input  logic [5:0] set_hour,
    input  logic [5:0] set_min,
    input  logic       alarm_en,
    input  logic       snooze,
    input  logic       stop,
    output logic [5:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic       ring,
    output logic       beep,
    output logic       missed,
    output logic [1:0] state
);

    localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);
    localparam logic [9:0] SNZ_TICKS = 10'(SNOOZE_MIN * SEC_PER_MIN);
    localparam logic [2:0] SNZ_LIMIT = 3'(MAX_SNOOZE);

    state_t     st;
    logic [7:0] ring_cnt;
    logic [2:0] snooze_cnt;
    logic [9:0] snz_timer;
    logic       match;

    alarm_match u_match (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .set_hour   (set_hour),
        .set_min    (set_min),
        .tick_sec   (tick_sec),
        .alarm_en   (alarm_en),
        .sec        (sec),
        .min        (min),
        .hour       (hour),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .match      (match)
    );

    assign state = st;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st         <= ST_IDLE;
            ring       <= 1'b0;
            beep       <= 1'b0;
            missed     <= 1'b0;
            ring_cnt   <= 8'd0;
            snooze_cnt <= 3'd0;
            snz_timer  <= 10'd0;
        end else begin
            // Acknowledging clears the missed flag whatever the state.
            if (stop) begin
                missed <= 1'b0;
            end

            // Disarm, stop and the illegal code all land in IDLE; stop in IDLE
            // also outranks a same-cycle match.
            if (!alarm_en || stop || st == ST_BAD) begin
                st         <= ST_IDLE;
                ring       <= 1'b0;
                beep       <= 1'b0;
                ring_cnt   <= 8'd0;
                snooze_cnt <= 3'd0;
                snz_timer  <= 10'd0;
            end else begin
                case (st)
                    ST_RINGING: begin
                        if (snooze && snooze_cnt < SNZ_LIMIT) begin
                            st         <= ST_SNOOZE;
                            ring       <= 1'b0;
                            beep       <= 1'b0;
                            snooze_cnt <= snooze_cnt + 3'd1;
                            snz_timer  <= SNZ_TICKS;
                        end else if (tick_sec) begin
                            if (ring_cnt == RING_LAST) begin
                                st         <= ST_IDLE;
                                ring       <= 1'b0;
                                beep       <= 1'b0;
                                missed     <= 1'b1;
                                ring_cnt   <= 8'd0;
                                snooze_cnt <= 3'd0;
                                snz_timer  <= 10'd0;
                            end else begin
                                ring_cnt <= ring_cnt + 8'd1;
                                beep     <= ~beep;
                            end
                        end
                    end
                    ST_SNOOZE: begin
                        if (tick_sec) begin
                            if (snz_timer == 10'd1) begin
                                st       <= ST_RINGING;
                                ring     <= 1'b1;
                                beep     <= 1'b1;
                                ring_cnt <= 8'd0;
                            end
                            snz_timer <= snz_timer - 10'd1;
                        end
                    end
                    ST_IDLE: begin
                        if (match) begin
                            st       <= ST_RINGING;
                            ring     <= 1'b1;
                            beep     <= 1'b1;
                            ring_cnt <= 8'd0;
                        end
                    end
                    default: begin
                        st <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb/tb_alarm_ctrl.sv - scoreboard bench for alarm_ctrl with directed and random stimulus
module tb_alarm_ctrl;

    localparam int RING_SEC   = 60;
    localparam int SNOOZE_MIN = 5;
    localparam int MAX_SNOOZE = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_sec = 1'b0;
    logic [5:0] sec = '0, min = '0, hour = '0;
    logic       load = 1'b0;
    logic [5:0] set_hour = '0, set_min = '0;
    logic       alarm_en = 1'b0;
    logic       snooze = 1'b0, stop = 1'b0;
    logic [5:0] alarm_hour, alarm_min;
    logic       ring, beep, missed;
    logic [1:0] state;

    alarm_ctrl #(.RING_SEC(RING_SEC), .SNOOZE_MIN(SNOOZE_MIN), .MAX_SNOOZE(MAX_SNOOZE)) dut (
        .clk(clk), .rst_n(rst_n), .tick_sec(tick_sec), .sec(sec), .min(min), .hour(hour),
        .load(load), .set_hour(set_hour), .set_min(set_min), .alarm_en(alarm_en),
        .snooze(snooze), .stop(stop), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .ring(ring), .beep(beep), .missed(missed), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       ring;
        logic       beep;
        logic       missed;
        logic [5:0] ah;
        logic [5:0] am;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    string phase = "reset";

    // Reference: mode 0 idle, 1 ringing, 2 snoozing; rung counts ring seconds elapsed.
    int mode = 0, rung = 0, snz_left = 0, snoozes_used = 0;
    bit m_beep = 0, m_missed = 0;
    int m_ah = 0, m_am = 0;
    int t_h = 0, t_m = 0, t_s = 0;

    task automatic model_go_idle();
        mode = 0; rung = 0; snoozes_used = 0; m_beep = 0;
    endtask

    task automatic model_cycle();
        bit hit;
        if (!rst_n) begin
            model_go_idle();
            snz_left = 0; m_missed = 0; m_ah = 0; m_am = 0;
            return;
        end
        hit = tick_sec && alarm_en && int'(hour) == m_ah && int'(min) == m_am && sec == 6'd0;
        if (load && int'(set_hour) <= 23 && int'(set_min) <= 59) begin
            m_ah = int'(set_hour); m_am = int'(set_min);
        end
        if (stop) m_missed = 0;
        if (!alarm_en || stop) begin
            model_go_idle();
        end else if (mode == 1) begin
            if (snooze && snoozes_used < MAX_SNOOZE) begin
                mode = 2; snoozes_used++; snz_left = SNOOZE_MIN * 60; m_beep = 0;
            end else if (tick_sec) begin
                rung++;
                m_beep = !m_beep;
                if (rung == RING_SEC) begin
                    model_go_idle();
                    m_missed = 1;
                end
            end
        end else if (mode == 2) begin
            if (tick_sec) begin
                snz_left--;
                if (snz_left == 0) begin
                    mode = 1; rung = 0; m_beep = 1;
                end
            end
        end else if (hit) begin
            mode = 1; rung = 0; m_beep = 1;
        end
    endtask

    task automatic step();
        obs_t e;
        model_cycle();
        e.st = 2'(mode);
        e.ring = (mode == 1);
        e.beep = m_beep;
        e.missed = m_missed;
        e.ah = 6'(m_ah);
        e.am = 6'(m_am);
        exp_q.push_back(e);
        tag_q.push_back(phase);
        @(negedge clk);
        rst_n = 1'b1; tick_sec = 1'b0; load = 1'b0; snooze = 1'b0; stop = 1'b0;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        t_h = h; t_m = m; t_s = s;
        hour = 6'(h); min = 6'(m); sec = 6'(s);
    endtask

    task automatic tick_step();
        t_s++;
        if (t_s == 60) begin t_s = 0; t_m++; end
        if (t_m == 60) begin t_m = 0; t_h++; end
        if (t_h == 24) t_h = 0;
        set_time(t_h, t_m, t_s);
        tick_sec = 1'b1;
        step();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick_step();
            step();
        end
    endtask

    task automatic trigger();
        set_time(7, 29, 59);
        step();
        tick_step();
    endtask

    initial begin : monitor
        obs_t  e, got;
        string tg;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tg = tag_q.pop_front();
                got = {state, ring, beep, missed, alarm_hour, alarm_min};
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL %s @%0t: got state=%0d ring=%0b beep=%0b missed=%0b alarm=%0d:%0d, required state=%0d ring=%0b beep=%0b missed=%0b alarm=%0d:%0d",
                             tg, $time, got.st, got.ring, got.beep, got.missed, got.ah, got.am,
                             e.st, e.ring, e.beep, e.missed, e.ah, e.am);
                end
            end
        end
    end

    initial begin : stimulus
        @(negedge clk);
        rst_n = 1'b0; load = 1'b1; set_hour = 6'd7; set_min = 6'd30;
        step();
        rst_n = 1'b0;
        step();

        phase = "load";
        alarm_en = 1'b1;
        set_time(7, 29, 50);
        load = 1'b1; set_hour = 6'd7; set_min = 6'd30;
        step();
        phase = "load_bad";
        load = 1'b1; set_hour = 6'd24; set_min = 6'd10;
        step();
        load = 1'b1; set_hour = 6'd5; set_min = 6'd60;
        step();

        phase = "match";
        ticks(10);
        phase = "timeout";
        ticks(RING_SEC);
        step();
        stop = 1'b1;
        step();

        phase = "snooze";
        trigger();
        repeat (MAX_SNOOZE) begin
            snooze = 1'b1;
            step();
            ticks(SNOOZE_MIN * 60);
        end
        phase = "snooze_limit";
        snooze = 1'b1;
        step();
        ticks(5);
        phase = "stop_snooze";
        stop = 1'b1; snooze = 1'b1;
        step();

        phase = "en_drop";
        trigger();
        snooze = 1'b1;
        step();
        ticks(3);
        alarm_en = 1'b0;
        step();
        step();
        alarm_en = 1'b1;
        step();

        phase = "reset_ring";
        trigger();
        ticks(2);
        t_s++;
        set_time(t_h, t_m, t_s);
        tick_sec = 1'b1; load = 1'b1; set_hour = 6'd9; set_min = 6'd15; rst_n = 1'b0;
        step();
        step();

        phase = "random";
        alarm_en = 1'b1;
        load = 1'b1; set_hour = 6'd6; set_min = 6'd45;
        step();
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 999) < 2) rst_n = 1'b0;
            if ($urandom_range(0, 99) < 2) begin
                load = 1'b1;
                set_hour = 6'($urandom_range(0, 26));
                set_min = 6'($urandom_range(0, 63));
            end
            if (mode == 0 && m_am > 0 && $urandom_range(0, 99) < 3)
                set_time(m_ah, m_am - 1, 58 + int'($urandom_range(0, 1)));
            if (alarm_en) begin
                if ($urandom_range(0, 999) < 5) alarm_en = 1'b0;
            end else if ($urandom_range(0, 99) < 30) begin
                alarm_en = 1'b1;
            end
            if ($urandom_range(0, 99) < 4) snooze = 1'b1;
            if (alarm_en && $urandom_range(0, 99) < 1) stop = 1'b1;
            if ($urandom_range(0, 1) == 1) tick_step();
            else step();
        end

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
